// File: rtl/resp_pkg.sv
// ---------------------------------------------------------------------------
// resp_pkg
// Shared definitions for the memory/IO bus responder.
//   resp_state_t   : bus-cycle FSM states
//   IO_PORT_COUNT  : number of IO port registers decoded on addr[1:0]
//   STATUS_HALT    : S1:S0 encoding of a halt cycle (no access accepted)
// Optional feature macro: RESP_WAIT_EN (adds the WAIT state).
// ---------------------------------------------------------------------------
package resp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
`ifdef RESP_WAIT_EN
        WAIT  = 3'd2,
`endif
        READ  = 3'd3,
        WRITE = 3'd4
    } resp_state_t;

    localparam int         IO_PORT_COUNT = 4;
    localparam logic [1:0] STATUS_HALT   = 2'b00;

endpackage

// File: rtl/resp_ram.sv
// ---------------------------------------------------------------------------
// resp_ram
// 256x8 storage page for the responder. Synchronous write, registered read.
// Contents are deliberately not reset.
// Ports:
//   clk     : clock
//   we      : write enable, commits wdata to mem[addr] on the rising edge
//   addr    : byte address within the page
//   wdata   : write data
//   rd_data : mem[addr] as sampled on the previous rising edge
// ---------------------------------------------------------------------------
module resp_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rd_data
);

    logic [7:0] mem [256];

    // The read port runs every clock so the data for the latched address is
    // already waiting by the time the FSM starts driving the bus.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// Bus-side responder for a multiplexed address/data bus. Serves one 256-byte
// RAM page (memory cycles, haddress == MEM_PAGE) and four IO port registers
// (IO cycles, decoded on addr[1:0]).
// Parameters:
//   MEM_PAGE    : high address byte selecting the RAM page
//   WAIT_STATES : READY-low clocks per access (used only with RESP_WAIT_EN)
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   ALE              : address latch enable
//   RDn, WRn         : active-low read / write strobes
//   IOMn             : 1 = IO cycle, 0 = memory cycle
//   S1, S0           : bus status, 2'b00 = halt
//   haddress, ad_in  : high address byte, multiplexed low address/data
//   ad_out, ad_oe    : read data and its drive enable
//   READY            : 0 = insert wait state
// Optional feature macro: RESP_WAIT_EN. Without it READY is tied high and
// WAIT_STATES is ignored.
// ---------------------------------------------------------------------------
module mem_io_responder
    import resp_pkg::*;
#(
    parameter logic [7:0] MEM_PAGE    = 8'h00,
    parameter logic [1:0] WAIT_STATES = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ALE,
    input  logic       RDn,
    input  logic       WRn,
    input  logic       IOMn,
    input  logic       S1,
    input  logic       S0,
    input  logic [7:0] haddress,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       READY
);

    resp_state_t state;
    logic [15:0] addr;
    logic        iom;
    logic [7:0]  wdata;
    logic [7:0]  ports [IO_PORT_COUNT];
    logic [7:0]  rd_data;
    logic [7:0]  read_value;
    logic        selected;
    logic        halted;
    logic        both_low;
    logic        commit;

    assign halted   = ({S1, S0} == STATUS_HALT);
    assign both_low = !RDn && !WRn;
    assign selected = iom || (addr[15:8] == MEM_PAGE);

    // A write lands on the first edge WRn is seen high in WRITE; a new ALE,
    // a halt or reset at that same edge cancels it.
    assign commit = (state == WRITE) && WRn && !ALE && !halted;

    always_comb begin
        read_value = rd_data;
        if (iom) begin
            read_value = ports[addr[1:0]];
        end
    end

    resp_ram u_ram (
        .clk     (clk),
        .we      (commit && !iom && rst),
        .addr    (addr[7:0]),
        .wdata   (wdata),
        .rd_data (rd_data)
    );

`ifdef RESP_WAIT_EN
    logic       ready_q;
    logic [1:0] wait_cnt;
    assign READY = ready_q;
`else
    logic unused_wait_states;
    assign unused_wait_states = ^WAIT_STATES;
    assign READY = 1'b1;
`endif

    // Bus-cycle FSM. ALE has priority over everything except reset so a new
    // address always abandons the access in flight; halt status and
    // both-strobes-low abort back to IDLE with no drive and no commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            addr   <= '0;
            iom    <= 1'b0;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            wdata  <= '0;
            for (int i = 0; i < IO_PORT_COUNT; i++) begin
                ports[i] <= '0;
            end
`ifdef RESP_WAIT_EN
            ready_q  <= 1'b1;
            wait_cnt <= '0;
`endif
        end else begin
            if (commit && iom) begin
                ports[addr[1:0]] <= wdata;
            end

            if (ALE) begin
                addr   <= {haddress, ad_in};
                iom    <= IOMn;
                state  <= ADDR;
                ad_oe  <= 1'b0;
                ad_out <= '0;
`ifdef RESP_WAIT_EN
                ready_q <= 1'b1;
`endif
            end else if (state != IDLE && halted) begin
                state  <= IDLE;
                ad_oe  <= 1'b0;
                ad_out <= '0;
`ifdef RESP_WAIT_EN
                ready_q <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        ad_oe  <= 1'b0;
                        ad_out <= '0;
                    end
                    ADDR: begin
                        if (!selected || both_low) begin
                            state <= IDLE;
                        end else if (!RDn || !WRn) begin
                            wdata <= ad_in;
`ifdef RESP_WAIT_EN
                            if (WAIT_STATES != 2'd0) begin
                                state    <= WAIT;
                                ready_q  <= 1'b0;
                                wait_cnt <= WAIT_STATES - 2'd1;
                            end else
`endif
                            if (!RDn) begin
                                state <= READ;
                            end else begin
                                state <= WRITE;
                            end
                        end
                    end
`ifdef RESP_WAIT_EN
                    // The last wait clock hands straight over to the data
                    // phase so read data appears together with READY.
                    WAIT: begin
                        if (both_low || (RDn && WRn)) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            if (!WRn) begin
                                wdata <= ad_in;
                            end
                            if (wait_cnt != 2'd0) begin
                                wait_cnt <= wait_cnt - 2'd1;
                            end else begin
                                ready_q <= 1'b1;
                                if (!RDn) begin
                                    state  <= READ;
                                    ad_oe  <= 1'b1;
                                    ad_out <= read_value;
                                end else begin
                                    state <= WRITE;
                                end
                            end
                        end
                    end
`endif
                    // Drive lags the strobe by one clock, so the edge that
                    // sees RDn high still drives and IDLE drops it next.
                    READ: begin
                        if (both_low) begin
                            state  <= IDLE;
                            ad_oe  <= 1'b0;
                            ad_out <= '0;
                        end else begin
                            ad_oe  <= 1'b1;
                            ad_out <= read_value;
                            if (RDn) begin
                                state <= IDLE;
                            end
                        end
                    end
                    WRITE: begin
                        if (both_low) begin
                            state <= IDLE;
                        end else if (!WRn) begin
                            wdata <= ad_in;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        ad_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_io_responder
// Directed bench for mem_io_responder: memory and IO writes/reads, page
// decode, halt, dual-strobe error, ALE abandon and reset during an access.
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, i.e. after exactly one rising edge has consumed the inputs.
// ---------------------------------------------------------------------------
module tb_mem_io_responder;

    localparam logic [1:0] RUN = 2'b11;
`ifdef RESP_WAIT_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif
    localparam int   LAT        = (WS == 0) ? 1 : WS;
    localparam logic READY_WAIT = (WS == 0) ? 1'b1 : 1'b0;

    logic       clk;
    logic       rst;
    logic       ALE;
    logic       RDn;
    logic       WRn;
    logic       IOMn;
    logic       S1;
    logic       S0;
    logic [7:0] haddress;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       READY;

    int vec_count       = 0;
    int miscompare_count = 0;

    mem_io_responder #(
        .MEM_PAGE    (8'h00),
        .WAIT_STATES (2'd2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ALE      (ALE),
        .RDn      (RDn),
        .WRn      (WRn),
        .IOMn     (IOMn),
        .S1       (S1),
        .S0       (S0),
        .haddress (haddress),
        .ad_in    (ad_in),
        .ad_out   (ad_out),
        .ad_oe    (ad_oe),
        .READY    (READY)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and count it
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one clock worth of bus inputs, then wait for the next falling edge
    task automatic applyStimulus(input logic ale, input logic rdn, input logic wrn, input logic iomn,
                                 input logic [1:0] status, input logic [7:0] haddr, input logic [7:0] ad);
        ALE      = ale;
        RDn      = rdn;
        WRn      = wrn;
        IOMn     = iomn;
        {S1, S0} = status;
        haddress = haddr;
        ad_in    = ad;
        @(negedge clk);
    endtask

    task automatic busIdle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, RUN, 8'h00, 8'h00);
    endtask

    // Address phase plus three WRn-low clocks: enough to reach WRITE with or
    // without wait states
    task automatic doWriteBegin(input logic iomn, input logic [7:0] haddr, input logic [7:0] laddr,
                                input logic [7:0] data);
        applyStimulus(1'b1, 1'b1, 1'b1, iomn, RUN, haddr, laddr);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, iomn, RUN, haddr, data);
    endtask

    task automatic doWrite(input logic iomn, input logic [7:0] haddr, input logic [7:0] laddr,
                           input logic [7:0] data);
        doWriteBegin(iomn, haddr, laddr, data);
        applyStimulus(1'b0, 1'b1, 1'b1, iomn, RUN, haddr, 8'h00);
        busIdle();
    endtask

    // Full read cycle with exact drive timing checks
    task automatic doRead(input string tag, input logic iomn, input logic [7:0] haddr,
                          input logic [7:0] laddr, input logic [7:0] expected);
        applyStimulus(1'b1, 1'b1, 1'b1, iomn, RUN, haddr, laddr);
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, iomn, RUN, haddr, 8'h00);
            checkOutput({tag, "_oe_early"}, {7'd0, ad_oe}, 8'd0);
            checkOutput({tag, "_ready_wait"}, {7'd0, READY}, {7'd0, READY_WAIT});
        end
        applyStimulus(1'b0, 1'b0, 1'b1, iomn, RUN, haddr, 8'h00);
        checkOutput({tag, "_oe"}, {7'd0, ad_oe}, 8'd1);
        checkOutput({tag, "_data"}, ad_out, expected);
        checkOutput({tag, "_ready"}, {7'd0, READY}, 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, iomn, RUN, haddr, 8'h00);
        checkOutput({tag, "_oe_hold"}, {7'd0, ad_oe}, 8'd1);
        busIdle();
        checkOutput({tag, "_oe_fall"}, {7'd0, ad_oe}, 8'd0);
    endtask

    initial begin
        rst      = 1'b0;
        ALE      = 1'b0;
        RDn      = 1'b1;
        WRn      = 1'b1;
        IOMn     = 1'b0;
        {S1, S0} = RUN;
        haddress = 8'h00;
        ad_in    = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_oe", {7'd0, ad_oe}, 8'd0);
        checkOutput("reset_data", ad_out, 8'h00);
        checkOutput("reset_ready", {7'd0, READY}, 8'd1);
        rst = 1'b1;
        busIdle();

        // Memory write then read back, two locations
        doWrite(1'b0, 8'h00, 8'h10, 8'h43);
        doRead("mem_0010", 1'b0, 8'h00, 8'h10, 8'h43);
        doWrite(1'b0, 8'h00, 8'hFF, 8'h5A);
        doRead("mem_00ff", 1'b0, 8'h00, 8'hFF, 8'h5A);
        doRead("mem_0010_again", 1'b0, 8'h00, 8'h10, 8'h43);

        // IO ports decode on addr[1:0] only, haddress ignored
        doWrite(1'b1, 8'h00, 8'h06, 8'hA5);
        doRead("io_port2", 1'b1, 8'h00, 8'h02, 8'hA5);
        doWrite(1'b1, 8'h00, 8'hFF, 8'h3C);
        doRead("io_port3", 1'b1, 8'h00, 8'h07, 8'h3C);
        doRead("io_port2_alias", 1'b1, 8'h37, 8'hFE, 8'hA5);

        // Other page: writes ignored, reads never driven
        doWrite(1'b0, 8'h20, 8'h10, 8'hEE);
        doRead("mem_0010_after_offpage", 1'b0, 8'h00, 8'h10, 8'h43);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, RUN, 8'h20, 8'h10);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, RUN, 8'h20, 8'h00);
            checkOutput("offpage_oe", {7'd0, ad_oe}, 8'd0);
            checkOutput("offpage_ready", {7'd0, READY}, 8'd1);
        end
        busIdle();

        // Both strobes low: no drive, no commit
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, RUN, 8'h00, 8'h10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, RUN, 8'h00, 8'hFF);
            checkOutput("both_low_oe", {7'd0, ad_oe}, 8'd0);
        end
        busIdle();
        doRead("mem_0010_after_both_low", 1'b0, 8'h00, 8'h10, 8'h43);

        // Halt status blocks the access
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, RUN, 8'h00, 8'h10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
            checkOutput("halt_oe", {7'd0, ad_oe}, 8'd0);
            checkOutput("halt_ready", {7'd0, READY}, 8'd1);
        end
        busIdle();

        // New ALE at the would-be commit edge abandons the write
        doWriteBegin(1'b0, 8'h00, 8'h10, 8'h77);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, RUN, 8'h00, 8'h10);
        checkOutput("abandon_oe", {7'd0, ad_oe}, 8'd0);
        busIdle();
        doRead("mem_0010_after_abandon", 1'b0, 8'h00, 8'h10, 8'h43);

        // Reset while driving read data drops the drive at that edge
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, RUN, 8'h00, 8'hFF);
        repeat (LAT + 1) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, RUN, 8'h00, 8'h00);
        checkOutput("pre_reset_oe", {7'd0, ad_oe}, 8'd1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, RUN, 8'h00, 8'h00);
        checkOutput("reset_read_oe", {7'd0, ad_oe}, 8'd0);
        checkOutput("reset_read_data", ad_out, 8'h00);
        rst = 1'b1;
        busIdle();

        // Reset on the commit edge of a write: no commit, ports cleared
        doWrite(1'b1, 8'h00, 8'h06, 8'hA5);
        doRead("io_port2_rewrite", 1'b1, 8'h00, 8'h02, 8'hA5);
        doWriteBegin(1'b0, 8'h00, 8'h10, 8'h99);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, RUN, 8'h00, 8'h00);
        checkOutput("reset_write_oe", {7'd0, ad_oe}, 8'd0);
        checkOutput("reset_write_ready", {7'd0, READY}, 8'd1);
        rst = 1'b1;
        busIdle();
        doRead("io_port2_cleared", 1'b1, 8'h00, 8'h02, 8'h00);
        doRead("io_port3_cleared", 1'b1, 8'h00, 8'h03, 8'h00);
        doRead("mem_0010_kept", 1'b0, 8'h00, 8'h10, 8'h43);
        doRead("mem_00ff_kept", 1'b0, 8'h00, 8'hFF, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
